// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the rx FSM state type.
package eth_pkg;
    localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
    localparam logic [7:0]  ETH_SFD        = 8'hD5;
    localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam int          ETH_HDR_LEN    = 14;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_HEADER,
        RX_PAYLOAD,
        RX_DROP
    } rx_state_e;
endpackage

// File: rtl/eth_mac_header_rx.sv
// GMII rx front end: preamble/SFD detect, 14-byte MAC header capture, payload+FCS forwarding.
// Latency: header_valid 1 cycle after header byte 13; payload 2 cycles rxd->payload_data.
// Backpressure: none, GMII cannot stall. ETH_RX_ADDR_FILTER_EN drops frames not addressed to us.
module eth_mac_header_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
    parameter int          PREAMBLE_MIN = 3
) (
    input  logic        mac_gmii_rx_clk,
    input  logic        mac_gmii_rx_rst,
    input  logic [7:0]  mac_gmii_rxd,
    input  logic        mac_gmii_rx_dv,
    input  logic        mac_gmii_rx_er,
    output logic        preamble_sfd_valid,
    output logic [47:0] mac_d_addr,
    output logic [47:0] mac_s_addr,
    output logic [15:0] eth_type,
    output logic        addr_match,
    output logic        header_valid,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        payload_last,
    output logic        frame_err
);

    localparam logic [2:0] PRE_MIN      = 3'(PREAMBLE_MIN);
    localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_LEN - 1);

    rx_state_e   state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [47:0] d_addr_q, d_addr_d;
    logic [47:0] s_addr_q, s_addr_d;
    logic [15:0] type_q, type_d;
    logic        psv_q, psv_d;
    logic        match_q, match_d;
    logic        hv_q, hv_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [7:0]  pd_q, pd_d;
    logic        pv_q, pv_d;
    logic        pl_q, pl_d;
    logic        err_q, err_d;
    logic        hit;

    // Destination is complete by the time byte 13 arrives, so the match uses the registered value.
    assign hit = (d_addr_q == LOCAL_MAC) || (d_addr_q == MAC_BCAST);

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        idx_d      = idx_q;
        d_addr_d   = d_addr_q;
        s_addr_d   = s_addr_q;
        type_d     = type_q;
        psv_d      = psv_q;
        match_d    = match_q;
        hv_d       = 1'b0;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pd_d       = 8'h00;
        pv_d       = 1'b0;
        pl_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (mac_gmii_rx_dv && mac_gmii_rxd == ETH_PREAMBLE) begin
                    state_d   = RX_PREAMBLE;
                    pre_cnt_d = 3'd1;
                end
            end
            RX_PREAMBLE: begin
                if (!mac_gmii_rx_dv) begin
                    state_d = RX_IDLE;
                end else if (mac_gmii_rxd == ETH_PREAMBLE) begin
                    if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                end else if (mac_gmii_rxd == ETH_SFD && pre_cnt_q >= PRE_MIN) begin
                    state_d = RX_HEADER;
                    idx_d   = 4'd0;
                    psv_d   = 1'b1;
                    match_d = 1'b0;
                end else begin
                    state_d = RX_DROP;
                end
            end
            RX_HEADER: begin
                if (!mac_gmii_rx_dv) begin
                    err_d   = 1'b1;
                    psv_d   = 1'b0;
                    state_d = RX_IDLE;
                end else if (mac_gmii_rx_er) begin
                    err_d   = 1'b1;
                    psv_d   = 1'b0;
                    state_d = RX_DROP;
                end else begin
                    if (idx_q < 4'd6)
                        d_addr_d = {d_addr_q[39:0], mac_gmii_rxd};
                    else if (idx_q < 4'd12)
                        s_addr_d = {s_addr_q[39:0], mac_gmii_rxd};
                    else
                        type_d = {type_q[7:0], mac_gmii_rxd};

                    if (idx_q == LAST_HDR_IDX) begin
                        match_d    = hit;
                        hold_vld_d = 1'b0;
`ifdef ETH_RX_ADDR_FILTER_EN
                        if (!hit) begin
                            psv_d   = 1'b0;
                            state_d = RX_DROP;
                        end else begin
                            hv_d    = 1'b1;
                            state_d = RX_PAYLOAD;
                        end
`else
                        hv_d    = 1'b1;
                        state_d = RX_PAYLOAD;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            RX_PAYLOAD: begin
                // The held byte goes out only once we know whether it ends the frame.
                if (!mac_gmii_rx_dv) begin
                    pv_d       = hold_vld_q;
                    pl_d       = hold_vld_q;
                    pd_d       = hold_vld_q ? hold_q : 8'h00;
                    hold_vld_d = 1'b0;
                    psv_d      = 1'b0;
                    state_d    = RX_IDLE;
                end else if (mac_gmii_rx_er) begin
                    err_d      = 1'b1;
                    psv_d      = 1'b0;
                    hold_vld_d = 1'b0;
                    state_d    = RX_DROP;
                end else begin
                    pv_d       = hold_vld_q;
                    pd_d       = hold_vld_q ? hold_q : 8'h00;
                    hold_d     = mac_gmii_rxd;
                    hold_vld_d = 1'b1;
                end
            end
            RX_DROP: begin
                if (!mac_gmii_rx_dv) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge mac_gmii_rx_clk or posedge mac_gmii_rx_rst) begin
        if (mac_gmii_rx_rst) begin
            state_q    <= RX_IDLE;
            pre_cnt_q  <= 3'd0;
            idx_q      <= 4'd0;
            d_addr_q   <= 48'd0;
            s_addr_q   <= 48'd0;
            type_q     <= 16'd0;
            psv_q      <= 1'b0;
            match_q    <= 1'b0;
            hv_q       <= 1'b0;
            hold_q     <= 8'd0;
            hold_vld_q <= 1'b0;
            pd_q       <= 8'd0;
            pv_q       <= 1'b0;
            pl_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            idx_q      <= idx_d;
            d_addr_q   <= d_addr_d;
            s_addr_q   <= s_addr_d;
            type_q     <= type_d;
            psv_q      <= psv_d;
            match_q    <= match_d;
            hv_q       <= hv_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pd_q       <= pd_d;
            pv_q       <= pv_d;
            pl_q       <= pl_d;
            err_q      <= err_d;
        end
    end

    assign preamble_sfd_valid = psv_q;
    assign mac_d_addr         = d_addr_q;
    assign mac_s_addr         = s_addr_q;
    assign eth_type           = type_q;
    assign addr_match         = match_q;
    assign header_valid       = hv_q;
    assign payload_data       = pd_q;
    assign payload_valid      = pv_q;
    assign payload_last       = pl_q;
    assign frame_err          = err_q;

endmodule

// File: tb/tb_eth_mac_header_rx.sv
// Scoreboard bench for eth_mac_header_rx: directed frames push expected events, a monitor checks them.
module tb_eth_mac_header_rx;
    import eth_pkg::*;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
`ifdef ETH_RX_ADDR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic        psv, amatch, hvld, pvld, plast, ferr;
    logic [47:0] daddr, saddr;
    logic [15:0] etype;
    logic [7:0]  pdata;

    eth_mac_header_rx dut (
        .mac_gmii_rx_clk   (clk),
        .mac_gmii_rx_rst   (rst),
        .mac_gmii_rxd      (rxd),
        .mac_gmii_rx_dv    (rx_dv),
        .mac_gmii_rx_er    (rx_er),
        .preamble_sfd_valid(psv),
        .mac_d_addr        (daddr),
        .mac_s_addr        (saddr),
        .eth_type          (etype),
        .addr_match        (amatch),
        .header_valid      (hvld),
        .payload_data      (pdata),
        .payload_valid     (pvld),
        .payload_last      (plast),
        .frame_err         (ferr)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
        logic        m;
        int          cyc;
    } hdr_exp_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         cyc;
    } pay_exp_t;

    hdr_exp_t hdr_q[$];
    pay_exp_t pay_q[$];
    int       err_q[$];
    int       psv_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic psv_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output with no expected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT event must match the head of its queue.
    hdr_exp_t he;
    pay_exp_t pe;
    int       ec;
    always @(negedge clk) begin
        if (!rst) begin
            if (psv && !psv_prev) begin
                if (psv_q.size() == 0) unexpected("psv_rise");
                else begin
                    ec = psv_q.pop_front();
                    check("psv_rise_cycle", 64'(cyc), 64'(ec));
                end
            end
            if (hvld) begin
                if (hdr_q.size() == 0) unexpected("header_valid");
                else begin
                    he = hdr_q.pop_front();
                    check("hdr_dst", 64'(daddr), 64'(he.d));
                    check("hdr_src", 64'(saddr), 64'(he.s));
                    check("hdr_type", 64'(etype), 64'(he.t));
                    check("hdr_match", 64'(amatch), 64'(he.m));
                    check("hdr_cycle", 64'(cyc), 64'(he.cyc));
                end
            end
            if (pvld) begin
                if (pay_q.size() == 0) unexpected("payload_valid");
                else begin
                    pe = pay_q.pop_front();
                    check("pay_data", 64'(pdata), 64'(pe.d));
                    check("pay_last", 64'(plast), 64'(pe.l));
                    check("pay_cycle", 64'(cyc), 64'(pe.cyc));
                end
            end
            if (ferr) begin
                if (err_q.size() == 0) unexpected("frame_err");
                else begin
                    ec = err_q.pop_front();
                    check("err_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
        psv_prev = psv;
    end

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_dv = dv;
        rx_er = er;
        rxd   = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psv"}, 64'(psv), 64'd0);
        check({tag, "_dst"}, 64'(daddr), 64'd0);
        check({tag, "_src"}, 64'(saddr), 64'd0);
        check({tag, "_type"}, 64'(etype), 64'd0);
        check({tag, "_match"}, 64'(amatch), 64'd0);
        check({tag, "_hvld"}, 64'(hvld), 64'd0);
        check({tag, "_pdata"}, 64'(pdata), 64'd0);
        check({tag, "_pvld"}, 64'(pvld), 64'd0);
        check({tag, "_plast"}, 64'(plast), 64'd0);
        check({tag, "_ferr"}, 64'(ferr), 64'd0);
    endtask

    // Index i counts bytes after the SFD: 0..13 header, 14.. payload.
    task automatic send_frame(input int gap, input int npre, input logic [47:0] dst,
                              input logic [47:0] src, input logic [15:0] typ, input int nbytes,
                              input int er_idx, input int cut_idx, input int rst_idx);
        logic [111:0] h;
        logic [7:0]   b;
        logic         accept, hit, pass;
        hdr_exp_t     hx;
        pay_exp_t     px;
        h      = {dst, src, typ};
        accept = (npre >= 3);
        hit    = (dst == LOCAL) || (dst == 48'hFFFF_FFFF_FFFF);
        pass   = accept && (!FILT || hit);
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
        for (int p = 0; p < npre; p++) drive(1'b1, 1'b0, ETH_PREAMBLE);
        drive(1'b1, 1'b0, ETH_SFD);
        if (accept) psv_q.push_back(cyc + 1);
        for (int i = 0; i < 14 + nbytes; i++) begin
            if (i == cut_idx) break;
            if (i < 14) b = h[111 - 8*i -: 8];
            else        b = 8'((i - 14) * 37 + 5);
            drive(1'b1, (i == er_idx), b);
            if (i == rst_idx) begin
                #1 rst = 1'b1;
                #1 check_all_zero("reset_mid");
                hdr_q.delete();
                pay_q.delete();
                err_q.delete();
                psv_q.delete();
                rx_dv = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            if (accept && i == er_idx) begin
                err_q.push_back(cyc + 1);
                break;
            end
            if (i == 13 && pass) begin
                hx.d = dst; hx.s = src; hx.t = typ; hx.m = hit; hx.cyc = cyc + 1;
                hdr_q.push_back(hx);
            end
            if (i >= 14 && pass) begin
                px.d = b; px.l = (i == 13 + nbytes); px.cyc = cyc + 2;
                pay_q.push_back(px);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        if (accept && cut_idx >= 0 && cut_idx < 14) err_q.push_back(cyc + 1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (hdr_q.size() == 0 && pay_q.size() == 0 && err_q.size() == 0 && psv_q.size() == 0)
                break;
            @(posedge clk);
        end
        check({tag, "_pending_events"},
              64'(hdr_q.size() + pay_q.size() + err_q.size() + psv_q.size()), 64'd0);
        hdr_q.delete();
        pay_q.delete();
        err_q.delete();
        psv_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Unicast to us, ARP, 28 payload bytes
        send_frame(1, 7, LOCAL, 48'hAABB_CCDD_EEFF, ETHERTYPE_ARP, 28, -1, -1, -1);
        drain("unicast");
        // Broadcast
        send_frame(1, 7, 48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, ETHERTYPE_IPV4, 10, -1, -1, -1);
        drain("bcast");
        // Other station: filtered only when the filter is built in
        send_frame(1, 7, 48'h02_00_00_00_00_02, 48'h1122_3344_5566, ETHERTYPE_IPV4, 10, -1, -1, -1);
        drain("other");
        // Short preamble
        send_frame(1, 2, LOCAL, 48'hAABB_CCDD_EEFF, ETHERTYPE_ARP, 6, -1, -1, -1);
        drain("short_pre");
        // rx_er on header byte 8, then a good frame after one idle cycle
        send_frame(1, 7, LOCAL, 48'hAABB_CCDD_EEFF, ETHERTYPE_ARP, 6, 8, -1, -1);
        send_frame(0, 7, LOCAL, 48'h0102_0304_0506, ETHERTYPE_IPV4, 5, -1, -1, -1);
        drain("rx_er");
        // Runt: rx_dv drops after header byte 10, next frame 12 cycles later
        send_frame(1, 7, LOCAL, 48'hAABB_CCDD_EEFF, ETHERTYPE_ARP, 6, -1, 11, -1);
        send_frame(11, 3, 48'hFFFF_FFFF_FFFF, 48'hCAFE_0000_BEEF, ETHERTYPE_ARP, 4, -1, -1, -1);
        drain("runt");
        // Reset mid-payload, then a complete frame
        send_frame(1, 7, LOCAL, 48'hAABB_CCDD_EEFF, ETHERTYPE_ARP, 20, -1, -1, 19);
        send_frame(2, 7, LOCAL, 48'h0A0B_0C0D_0E0F, ETHERTYPE_IPV4, 8, -1, -1, -1);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_mac_header_rx.md
Name: eth_mac_header_rx

Overview:
- First stage of the GMII receive path; feeds the ARP/IP handlers.
- Finds the preamble and SFD on the raw GMII byte stream.
- Captures the 14-byte MAC header (destination MAC, source MAC, EtherType) and flags a valid header.
- Forwards the remaining frame bytes as a registered payload stream. The FCS is not stripped, so those bytes are payload plus FCS.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, station address used for destination filtering and match reporting.
- PREAMBLE_MIN, 3, minimum count of 0x55 bytes before SFD for the frame to be accepted (range 1..7).

Ports:
- mac_gmii_rx_clk  in  1  GMII receive clock, 125 MHz; the block's only clock.
- mac_gmii_rx_rst  in  1  asynchronous reset, active-high.
- mac_gmii_rxd  in  8  GMII receive data.
- mac_gmii_rx_dv  in  1  GMII data valid.
- mac_gmii_rx_er  in  1  GMII receive error.
- preamble_sfd_valid  out  1  level; high from the cycle after the SFD until the frame ends or is dropped.
- mac_d_addr  out  48  captured destination MAC; first wire byte is [47:40].
- mac_s_addr  out  48  captured source MAC; first wire byte is [47:40].
- eth_type  out  16  captured EtherType; first wire byte is [15:8].
- addr_match  out  1  destination equals LOCAL_MAC or ff:ff:ff:ff:ff:ff.
- header_valid  out  1  one-cycle pulse when all header fields are stable.
- payload_data  out  8  payload byte.
- payload_valid  out  1  payload byte qualifier.
- payload_last  out  1  marks the final byte of the frame.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: asynchronous, takes effect immediately at any point, including mid-frame.
  - FSM goes to IDLE.
  - All outputs go to 0; mac_d_addr, mac_s_addr and eth_type clear to 0.
- FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- IDLE:
  - rx_dv=1 and rxd=0x55 -> PREAMBLE, preamble count=1.
  - Any other byte is ignored.
- PREAMBLE:
  - rxd=0x55: increment count (saturates at 7; longer preambles are accepted).
  - rxd=0xD5 with count>=PREAMBLE_MIN: go to HEADER, byte index=0, assert preamble_sfd_valid next cycle.
  - rxd=0xD5 with count<PREAMBLE_MIN, or any other byte: go to DROP, no frame_err.
  - rx_dv=0: go to IDLE silently.
- HEADER:
  - Bytes 0..5 shift into mac_d_addr; bytes 6..11 into mac_s_addr; bytes 12..13 into eth_type.
  - Registers update in place; previous values are overwritten from the SFD onward.
  - After byte 13: header_valid pulses on the next cycle, with addr_match valid the same cycle; then go to PAYLOAD.
  - addr_match holds until the next SFD.
- PAYLOAD:
  - Each rx_dv byte enters a one-byte hold register.
  - A held byte is emitted on payload_data/payload_valid once the next rx_dv state is known.
  - payload_last=1 when the following cycle has rx_dv=0.
  - Latency: 2 cycles from rxd to payload_data.
  - rx_dv falling: emit the last byte, then go to IDLE and deassert preamble_sfd_valid in the same cycle payload_last is asserted.
- Errors:
  - rx_er=1 with rx_dv=1 in HEADER or PAYLOAD: frame_err pulses, preamble_sfd_valid drops, the held byte is discarded without payload_last, go to DROP.
  - rx_er with rx_dv=0 (carrier extension) is ignored.
  - rx_dv=0 during HEADER (runt frame): frame_err pulses, no header_valid, go to IDLE.
- DROP: outputs quiet; wait for rx_dv=0, then go to IDLE.
- Back-to-back frames: a single rx_dv=0 cycle between frames is enough to return to IDLE and accept a new preamble.

Optional Feature:
- Macro: ETH_RX_ADDR_FILTER_EN.
- Defined: frames with addr_match=0 are dropped at the end of the header.
  - header_valid and payload are suppressed; preamble_sfd_valid drops; go to DROP; no frame_err.
- Undefined: all frames pass; addr_match is still computed and reported.

Decomposition:
- Shared package eth_pkg holds:
  - ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, MAC_BCAST=48'hFFFF_FFFF_FFFF.
  - ETHERTYPE_ARP=16'h0806, ETHERTYPE_IPV4=16'h0800, ETH_HDR_LEN=14.
  - The rx state enum typedef.
- No sub-module; the payload hold stage stays inline.

Test Plan:
- 7x0x55, 0xD5, dst=02:00:00:00:00:01, src=AA:BB:CC:DD:EE:FF, type 0x0806, 28 payload bytes:
  - preamble_sfd_valid rises the cycle after the SFD.
  - header_valid pulses once, with mac_d_addr=48'h020000000001, mac_s_addr=48'hAABBCCDDEEFF, eth_type=16'h0806, addr_match=1.
  - 28 payload bytes appear, payload_last on byte 28, 2-cycle latency.
- Broadcast destination ff:ff:ff:ff:ff:ff: addr_match=1. Destination 02:00:00:00:00:02: addr_match=0.
  - With ETH_RX_ADDR_FILTER_EN: no header_valid and no payload.
  - Without it: full frame forwarded.
- 2x0x55 then 0xD5 (below PREAMBLE_MIN=3): no preamble_sfd_valid, no header_valid, no frame_err.
- rx_er asserted on header byte 8: one frame_err pulse, no header_valid; a following valid frame after 1 idle cycle is received correctly.
- rx_dv drops after header byte 10: frame_err pulse, FSM back in IDLE; a next frame 12 cycles later is accepted.
- Reset asserted mid-payload: all outputs 0 immediately. After release, a complete frame is received correctly.
